// File: rtl/spi_xfer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// spi_xfer_ctrl_pkg : shared state encodings and width defaults for the SPI
// transfer sequencer.   Rev 1.0
// ============================================================================
package spi_xfer_ctrl_pkg;

    localparam int SPI_CHAR_LEN_W = 7;
    localparam int SPI_SS_NB      = 8;
    localparam int SPI_HOLD_W     = 4;

    typedef enum logic [2:0] {
        SPI_ST_IDLE     = 3'd0,
        SPI_ST_CS_SETUP = 3'd1,
        SPI_ST_XFER     = 3'd2,
        SPI_ST_CS_HOLD  = 3'd3,
        SPI_ST_DONE     = 3'd4
    } spi_state_e;

    // States in which an auto-managed slave select is driven active.
    function automatic logic ss_active(input spi_state_e st);
        return (st == SPI_ST_CS_SETUP) || (st == SPI_ST_XFER) || (st == SPI_ST_CS_HOLD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_cnt.sv
`default_nettype none
// ============================================================================
// spi_bit_cnt : loadable down-counter with zero/one flags; saturates at 0.
// Rev 1.0
// ============================================================================
module spi_bit_cnt #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero,
    output logic         one
);

    localparam logic [W-1:0] C_ONE = W'(1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - C_ONE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == C_ONE);

endmodule
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// spi_xfer_ctrl : SPI transfer sequencer (clgen control, bit count, SS timing).
// Optional CS setup/hold states with SPI_CS_DELAY_EN.   Rev 1.0
// ============================================================================
module spi_xfer_ctrl
    import spi_xfer_ctrl_pkg::*;
#(
    parameter int CHAR_LEN_W = SPI_CHAR_LEN_W,
    parameter int SS_NB      = SPI_SS_NB,
    parameter int HOLD_W     = SPI_HOLD_W
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CHAR_LEN_W-1:0] char_len,
    input  logic [SS_NB-1:0]      ss_sel,
    input  logic                  auto_ss,
    input  logic [HOLD_W-1:0]     cs_dly,
    input  logic                  clk_pos_edge,
    input  logic                  clk_neg_edge,
    output logic                  clk_enable,
    output logic                  clk_go,
    output logic                  clk_last,
    output logic [CHAR_LEN_W:0]   bit_cnt,
    output logic                  busy,
    output logic                  done,
    output logic [SS_NB-1:0]      ss_pad_o
);

    localparam int CNT_W = CHAR_LEN_W + 1;

    spi_state_e         state_q, state_d;
    logic               clk_go_q, clk_go_d;
    logic [SS_NB-1:0]   ss_q, ss_d;
    logic               pos_edge_q;

    logic               cnt_clear, cnt_load, cnt_dec;
    logic               cnt_zero, cnt_one;
    logic [CNT_W-1:0]   cnt_load_val;
    logic [CNT_W-1:0]   cnt_val;
    logic               accept;
    logic               unused_sigs;

    assign accept = (state_q == SPI_ST_IDLE) && start && !abort;

    // A char_len of zero stands for the full 2**CHAR_LEN_W bits.
    assign cnt_load_val = (char_len == '0) ? {1'b1, {CHAR_LEN_W{1'b0}}}
                                           : {1'b0, char_len};

    spi_bit_cnt #(
        .W (CNT_W)
    ) u_bit_cnt (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

`ifdef SPI_CS_DELAY_EN
    localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign unused_sigs = ^{pos_edge_q, cnt_zero};
`else
    assign unused_sigs = ^{pos_edge_q, cnt_zero, cs_dly};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
`ifdef SPI_CS_DELAY_EN
        hold_cnt_d = hold_cnt_q;
`endif
        if ((state_q != SPI_ST_IDLE) && abort) begin
            state_d   = SPI_ST_IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                SPI_ST_IDLE: begin
                    if (accept) begin
                        cnt_load = 1'b1;
`ifdef SPI_CS_DELAY_EN
                        hold_cnt_d = cs_dly;
                        state_d    = SPI_ST_CS_SETUP;
`else
                        state_d    = SPI_ST_XFER;
`endif
                    end
                end
`ifdef SPI_CS_DELAY_EN
                // cs_dly of 0 or 1 both spend a single cycle here.
                SPI_ST_CS_SETUP: begin
                    if (hold_cnt_q <= C_HOLD_ONE) begin
                        state_d = SPI_ST_XFER;
                    end else begin
                        hold_cnt_d = hold_cnt_q - C_HOLD_ONE;
                    end
                end
                SPI_ST_CS_HOLD: begin
                    if (hold_cnt_q <= C_HOLD_ONE) begin
                        state_d = SPI_ST_DONE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - C_HOLD_ONE;
                    end
                end
`endif
                SPI_ST_XFER: begin
                    if (clk_neg_edge) begin
                        cnt_dec = 1'b1;
                        if (cnt_one) begin
`ifdef SPI_CS_DELAY_EN
                            hold_cnt_d = cs_dly;
                            state_d    = SPI_ST_CS_HOLD;
`else
                            state_d    = SPI_ST_DONE;
`endif
                        end
                    end
                end
                SPI_ST_DONE: begin
                    state_d = SPI_ST_IDLE;
                end
                default: begin
                    state_d = SPI_ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        clk_go_d = accept;
        if (!auto_ss) begin
            ss_d = ~ss_sel;
        end else if (ss_active(state_d)) begin
            ss_d = ~ss_sel;
        end else begin
            ss_d = '1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SPI_ST_IDLE;
            clk_go_q   <= 1'b0;
            ss_q       <= '1;
            pos_edge_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_go_q   <= clk_go_d;
            ss_q       <= ss_d;
            pos_edge_q <= clk_pos_edge;
        end
    end

    assign clk_enable = (state_q == SPI_ST_XFER);
    assign clk_go     = clk_go_q;
    assign clk_last   = cnt_one;
    assign bit_cnt    = cnt_val;
    assign busy       = (state_q != SPI_ST_IDLE);
    assign done       = (state_q == SPI_ST_DONE);
    assign ss_pad_o   = ss_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_xfer_ctrl : directed vector bench for spi_xfer_ctrl with a stubbed
// clock generator.   Rev 1.0
// ============================================================================
module tb_spi_xfer_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] char_len = '0;
    logic [7:0] ss_sel = '0;
    logic       auto_ss = 1'b1;
    logic [3:0] cs_dly = '0;
    logic       clk_pos_edge = 1'b0;
    logic       clk_neg_edge = 1'b0;
    logic       clk_enable, clk_go, clk_last, busy, done;
    logic [7:0] bit_cnt;
    logic [7:0] ss_pad_o;

    int total = 0;
    int bad   = 0;

    spi_xfer_ctrl #(
        .CHAR_LEN_W (7),
        .SS_NB      (8),
        .HOLD_W     (4)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .char_len     (char_len),
        .ss_sel       (ss_sel),
        .auto_ss      (auto_ss),
        .cs_dly       (cs_dly),
        .clk_pos_edge (clk_pos_edge),
        .clk_neg_edge (clk_neg_edge),
        .clk_enable   (clk_enable),
        .clk_go       (clk_go),
        .clk_last     (clk_last),
        .bit_cnt      (bit_cnt),
        .busy         (busy),
        .done         (done),
        .ss_pad_o     (ss_pad_o)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [6:0] len;
        logic [7:0] sel;
        logic       auto;
        logic [7:0] exp_ss;
        logic [7:0] exp_idle_ss;
        int         exp_bits;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   model;
        int   edges;
        int   trk;
        logic pulse;
        @(negedge clk_in);
        char_len = v.len;
        ss_sel   = v.sel;
        auto_ss  = v.auto;
        start    = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        chk($sformatf("v%0d clk_go", idx), clk_go, 1);
        chk($sformatf("v%0d busy", idx), busy, 1);
        chk($sformatf("v%0d bit_cnt_load", idx), bit_cnt, v.exp_bits);
        chk($sformatf("v%0d ss_active", idx), ss_pad_o, v.exp_ss);
        model = v.exp_bits;
        edges = 0;
        trk   = 0;
        pulse = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_in);
            if (pulse) begin
                if (model > 0) model--;
                edges++;
            end
            if (done) break;
            if (model > 0 && (bit_cnt !== model[7:0] || clk_last !== (model == 1) ||
                clk_enable !== 1'b1 || clk_go !== 1'b0 || ss_pad_o !== v.exp_ss))
                trk++;
            pulse = (c % 2 == 1);
            clk_neg_edge = pulse;
        end
        clk_neg_edge = 1'b0;
        chk($sformatf("v%0d track_errs", idx), trk, 0);
        chk($sformatf("v%0d edges", idx), edges, v.exp_bits);
        chk($sformatf("v%0d done", idx), done, 1);
        chk($sformatf("v%0d clk_enable_off", idx), clk_enable, 0);
        chk($sformatf("v%0d ss_at_done", idx), ss_pad_o, v.exp_idle_ss);
        chk($sformatf("v%0d bit_cnt_end", idx), bit_cnt, 0);
        @(negedge clk_in);
        chk($sformatf("v%0d done_pulse", idx), done, 0);
        chk($sformatf("v%0d busy_off", idx), busy, 0);
        chk($sformatf("v%0d ss_idle", idx), ss_pad_o, v.exp_idle_ss);
    endtask

    initial begin
        int go_n;
        int done_n;
        int seen_done;
        int setup_n;
        int hold_n;

        vecs[0] = '{len: 7'd8,   sel: 8'h04, auto: 1'b1, exp_ss: 8'hFB, exp_idle_ss: 8'hFF, exp_bits: 8};
        vecs[1] = '{len: 7'd0,   sel: 8'h04, auto: 1'b1, exp_ss: 8'hFB, exp_idle_ss: 8'hFF, exp_bits: 128};
        vecs[2] = '{len: 7'd1,   sel: 8'h01, auto: 1'b1, exp_ss: 8'hFE, exp_idle_ss: 8'hFF, exp_bits: 1};
        vecs[3] = '{len: 7'd127, sel: 8'h80, auto: 1'b1, exp_ss: 8'h7F, exp_idle_ss: 8'hFF, exp_bits: 127};
        vecs[4] = '{len: 7'd5,   sel: 8'h81, auto: 1'b0, exp_ss: 8'h7E, exp_idle_ss: 8'h7E, exp_bits: 5};

        // Reset values
        repeat (2) @(negedge clk_in);
        chk("rst clk_enable", clk_enable, 0);
        chk("rst clk_go", clk_go, 0);
        chk("rst clk_last", clk_last, 0);
        chk("rst bit_cnt", bit_cnt, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst ss", ss_pad_o, 8'hFF);
        rst_n = 1'b1;
        @(negedge clk_in);
        chk("idle busy", busy, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Abort after three neg edges
        @(negedge clk_in);
        char_len = 7'd8; ss_sel = 8'h04; auto_ss = 1'b1; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
`ifdef SPI_CS_DELAY_EN
        @(negedge clk_in);
`endif
        for (int k = 0; k < 3; k++) begin
            clk_neg_edge = 1'b1;
            @(negedge clk_in);
            clk_neg_edge = 1'b0;
            @(negedge clk_in);
        end
        chk("abort pre bit_cnt", bit_cnt, 5);
        abort = 1'b1;
        @(negedge clk_in);
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort clk_enable", clk_enable, 0);
        chk("abort ss", ss_pad_o, 8'hFF);
        chk("abort done", done, 0);
        seen_done = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (done) seen_done++;
        end
        chk("abort no_done", seen_done, 0);

        // Start while busy is dropped
        go_n = 0; done_n = 0;
        @(negedge clk_in);
        char_len = 7'd2; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            start = (c == 2);
            if (clk_go) go_n++;
            if (done) done_n++;
            clk_neg_edge = (c % 2 == 1);
        end
        clk_neg_edge = 1'b0; start = 1'b0;
        chk("busy_start go_count", go_n, 1);
        chk("busy_start done_count", done_n, 1);
        chk("busy_start busy_end", busy, 0);

        // start and abort together in IDLE
        @(negedge clk_in);
        start = 1'b1; abort = 1'b1;
        @(negedge clk_in);
        start = 1'b0; abort = 1'b0;
        chk("start_abort busy", busy, 0);
        chk("start_abort clk_go", clk_go, 0);
        @(negedge clk_in);
        chk("start_abort busy_later", busy, 0);

`ifdef SPI_CS_DELAY_EN
        cs_dly = 4'd3;
        @(negedge clk_in);
        char_len = 7'd2; ss_sel = 8'h04; auto_ss = 1'b1; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        setup_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (clk_enable) break;
            if (ss_pad_o == 8'hFB) setup_n++;
            @(negedge clk_in);
        end
        chk("cs setup_cycles", setup_n, 3);
        clk_neg_edge = 1'b1; @(negedge clk_in);
        clk_neg_edge = 1'b0; @(negedge clk_in);
        clk_neg_edge = 1'b1; @(negedge clk_in);
        clk_neg_edge = 1'b0;
        hold_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) break;
            if (ss_pad_o == 8'hFB && !clk_enable) hold_n++;
            @(negedge clk_in);
        end
        chk("cs hold_cycles", hold_n, 3);
        chk("cs done", done, 1);
        chk("cs ss_at_done", ss_pad_o, 8'hFF);
        cs_dly = 4'd0;
        @(negedge clk_in);
`else
        setup_n = 0;
        hold_n  = 0;
`endif

        // Reset asserted mid-transfer
        @(negedge clk_in);
        char_len = 7'd2; ss_sel = 8'h04; auto_ss = 1'b1; start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
`ifdef SPI_CS_DELAY_EN
        @(negedge clk_in);
`endif
        clk_neg_edge = 1'b1;
        @(negedge clk_in);
        clk_neg_edge = 1'b0;
        chk("midrst pre busy", busy, 1);
        chk("midrst pre clk_last", clk_last, 1);
        chk("midrst pre ss", ss_pad_o, 8'hFB);
        rst_n = 1'b0;
        #1;
        chk("midrst clk_enable", clk_enable, 0);
        chk("midrst clk_go", clk_go, 0);
        chk("midrst clk_last", clk_last, 0);
        chk("midrst bit_cnt", bit_cnt, 0);
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst ss", ss_pad_o, 8'hFF);
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        chk("post_rst busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
